rede_stream_ctrl: RTL
=====================

Name: rede_stream_ctrl

Overview:
Sequencer that wraps the rede_float network core. It buffers upstream 19-bit samples in an input FIFO and primes the network before releasing its reset. It answers the core's sample requests (req code 4'd1) and captures results (out_en code 4'd1) into an output FIFO behind a valid/ready master port. It replaces the file-driven stimulus with a streaming interface for system integration.

Parameters:
IAW, 4, input FIFO address width; depth 2^IAW samples
OAW, 3, output FIFO address width; depth 2^OAW results
PRIME_CNT, 4, samples required in input FIFO before network reset is released; legal range 1..2^IAW

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
flush  in  1  single-cycle pulse; drain input, re-prime network
s_data  in  19  signed upstream sample
s_valid  in  1  upstream sample valid
s_ready  out  1  upstream ready
net_rst  out  1  reset to network core, registered
net_in  out  19  signed sample to network core, registered
net_req  in  4  network request code; 4'd1 = consume next sample
net_out  in  28  signed network result
net_en  in  4  network output code; 4'd1 = net_out valid this cycle
m_data  out  28  signed result to downstream
m_valid  out  1  result valid
m_ready  in  1  downstream ready
underrun  out  1  sticky: request seen with input FIFO empty
overflow  out  1  sticky: result seen with output FIFO full
state_o  out  2  FSM state: 0 PRIME, 1 RUN, 2 DRAIN

Behaviour:
- Reset (rst=1 at edge): FSM=PRIME; both FIFOs empty; net_rst=1; net_in=0; m_valid=0; m_data=0; underrun=0; overflow=0; s_ready=0 on the cycle after reset, then per the rule below.
- s_ready = (state!=DRAIN) && input FIFO not full. Push when s_valid && s_ready at the edge.
- PRIME: net_rst=1. When input level >= PRIME_CNT, the next edge moves to RUN, pops the head into net_in and drives net_rst=0 in the same edge. The core therefore leaves reset with its first sample already present.
- RUN: net_req==4'd1 at an edge, FIFO non-empty: pop and update net_in on that edge. Result is visible one cycle after the request.
- RUN: net_req==4'd1 with FIFO empty: net_in holds its value; underrun set; FSM stays RUN.
- Other net_req codes: ignored.
- Simultaneous push and pop in the same cycle are both legal. A push into an empty FIFO is not poppable in the same cycle (no bypass). Level stays consistent; full and empty status is taken from the level before the edge.
- net_en==4'd1 at an edge (any state except PRIME): net_out is written to the output FIFO if not full. If full, the result is dropped and overflow is set. A simultaneous m_valid && m_ready pop frees no slot for that same write.
- m_data/m_valid: registered head of the output FIFO; m_data holds while m_valid && !m_ready.
- flush in RUN moves to DRAIN. flush in PRIME or DRAIN is ignored.
- DRAIN: s_ready=0; requests are still served from the input FIFO. When the input FIFO is empty, the next edge goes to PRIME with net_rst=1 and net_in=0. The output FIFO is not cleared.
- underrun/overflow clear only on rst.
- FIFO pointers wrap modulo 2^IAW / 2^OAW; level counters are IAW+1 / OAW+1 bits wide.

Optional Feature:
REDE_CTRL_STATS_EN
- Defined: adds outputs in_cnt[31:0] (samples delivered to net_in) and out_cnt[31:0] (results accepted into the output FIFO). Both reset to 0, count on events, and wrap at 2^32.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset then push samples 5,-3,7,100 (PRIME_CNT=4): net_rst stays 1 through the 4th push; one edge later net_rst=0 and net_in=5; state_o=1.
- RUN, net_req=4'd1 for 3 single cycles: net_in steps -3, 7, 100, each one cycle after the request. A 4th request with the FIFO empty keeps net_in=100 and sets underrun=1.
- net_en=4'd1 with net_out=28'sd-12345, m_ready=1: m_valid=1 with m_data=-12345. With m_ready=0 and 9 results (OAW=3), the 9th is dropped, overflow=1, and the 8 stored values drain in order.
- net_req=4'd2 and net_en=4'd3 pulses: no pop, no capture, flags unchanged.
- flush in RUN with 2 samples queued: s_ready=0; two requests empty the FIFO; the next edge gives state_o=0 and net_rst=1. Refill to 4 samples: re-release with the first new sample on net_in.
- rst asserted mid-RUN with both FIFOs partially full: the next edge shows all reset values, FIFOs empty and flags cleared. With REDE_CTRL_STATS_EN, in_cnt=out_cnt=0.

Source files
------------

// File: rtl/rede_stream_ctrl.sv
// Streaming sequencer around the rede_float network core: input FIFO with priming, output FIFO
// behind a valid/ready port. Optional REDE_CTRL_STATS_EN adds in_cnt/out_cnt event counters.
module rede_stream_ctrl #(
    parameter int unsigned IAW       = 4,
    parameter int unsigned OAW       = 3,
    parameter int unsigned PRIME_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [18:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        net_rst,
    output logic [18:0] net_in,
    input  logic [3:0]  net_req,
    input  logic [27:0] net_out,
    input  logic [3:0]  net_en,
    output logic [27:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        underrun,
    output logic        overflow,
`ifdef REDE_CTRL_STATS_EN
    output logic [31:0] in_cnt,
    output logic [31:0] out_cnt,
`endif
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {StPrime = 2'd0, StRun = 2'd1, StDrain = 2'd2} state_e;

    localparam logic [IAW:0] IFull    = (IAW + 1)'(2 ** IAW);
    localparam logic [IAW:0] PrimeLvl = (IAW + 1)'(PRIME_CNT);
    localparam logic [OAW:0] OFull    = (OAW + 1)'(2 ** OAW);

    state_e             state_q, state_d;
    logic [18:0]        imem_q [2 ** IAW];
    logic [27:0]        omem_q [2 ** OAW];
    logic [IAW-1:0]     irp_q, irp_d, iwp_q, iwp_d;
    logic [IAW:0]       ilvl_q, ilvl_d;
    logic [OAW-1:0]     orp_q, orp_d, owp_q, owp_d;
    logic [OAW:0]       olvl_q, olvl_d;
    logic               net_rst_q, net_rst_d;
    logic [18:0]        net_in_q, net_in_d;
    logic               m_valid_q, m_valid_d;
    logic [27:0]        m_data_q, m_data_d;
    logic               underrun_q, underrun_d;
    logic               overflow_q, overflow_d;
    logic               ready_en_q;
    logic               push, pop, req, cap, owr, opop;

    assign s_ready  = ready_en_q && (state_q != StDrain) && (ilvl_q != IFull);
    assign push     = s_valid && s_ready;
    assign req      = (net_req == 4'd1);
    assign cap      = (net_en == 4'd1) && (state_q != StPrime);
    // Full status is taken before the edge: a same-cycle downstream pop frees no slot.
    assign owr      = cap && (olvl_q != OFull);
    assign opop     = m_valid_q && m_ready;

    always_comb begin
        state_d    = state_q;
        net_rst_d  = net_rst_q;
        net_in_d   = net_in_q;
        underrun_d = underrun_q;
        pop        = 1'b0;
        case (state_q)
            StPrime: begin
                net_rst_d = 1'b1;
                if (ilvl_q >= PrimeLvl) begin
                    pop       = 1'b1;
                    state_d   = StRun;
                    net_rst_d = 1'b0;
                end
            end
            StRun: begin
                if (req) begin
                    if (ilvl_q != '0) pop = 1'b1;
                    else              underrun_d = 1'b1;
                end
                if (flush) state_d = StDrain;
            end
            StDrain: begin
                if (ilvl_q == '0) begin
                    state_d   = StPrime;
                    net_rst_d = 1'b1;
                    net_in_d  = '0;
                    if (req) underrun_d = 1'b1;
                end else if (req) begin
                    pop = 1'b1;
                end
            end
            default: state_d = StPrime;
        endcase
        if (pop) net_in_d = imem_q[irp_q];
        irp_d  = irp_q + IAW'(pop);
        iwp_d  = iwp_q + IAW'(push);
        ilvl_d = ilvl_q + (IAW + 1)'(push) - (IAW + 1)'(pop);

        overflow_d = overflow_q | (cap && (olvl_q == OFull));
        orp_d      = orp_q + OAW'(opop);
        owp_d      = owp_q + OAW'(owr);
        olvl_d     = olvl_q + (OAW + 1)'(owr) - (OAW + 1)'(opop);
        m_valid_d  = (olvl_d != '0);
        m_data_d   = m_data_q;
        // The new head may be the word being written on this very edge.
        if (olvl_d != '0) begin
            m_data_d = (owr && (owp_q == orp_d)) ? net_out : omem_q[orp_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StPrime;
            irp_q      <= '0;
            iwp_q      <= '0;
            ilvl_q     <= '0;
            orp_q      <= '0;
            owp_q      <= '0;
            olvl_q     <= '0;
            net_rst_q  <= 1'b1;
            net_in_q   <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            irp_q      <= irp_d;
            iwp_q      <= iwp_d;
            ilvl_q     <= ilvl_d;
            orp_q      <= orp_d;
            owp_q      <= owp_d;
            olvl_q     <= olvl_d;
            net_rst_q  <= net_rst_d;
            net_in_q   <= net_in_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            ready_en_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) imem_q[iwp_q] <= s_data;
        if (owr)  omem_q[owp_q] <= net_out;
    end

`ifdef REDE_CTRL_STATS_EN
    logic [31:0] in_cnt_q, out_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            in_cnt_q  <= in_cnt_q + 32'(pop);
            out_cnt_q <= out_cnt_q + 32'(owr);
        end
    end

    assign in_cnt  = in_cnt_q;
    assign out_cnt = out_cnt_q;
`endif

    assign net_rst  = net_rst_q;
    assign net_in   = net_in_q;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign underrun = underrun_q;
    assign overflow = overflow_q;
    assign state_o  = state_q;

endmodule
